// File: rtl/ltc2656_update_scheduler.sv
// ltc2656_update_scheduler
// Keeps the eight LTC2656 DAC channels in step with their requested values.
// Any channel whose request differs from the last written value (or that is
// force-flagged after reset) is picked round-robin. A single 24-bit
// write-and-update command is then handed to the SPI master. The dac_X
// outputs hold the value last confirmed on the part.

module ltc2656_update_scheduler #(
    parameter logic [3:0] CMD_WR_UPD = 4'b0011,
    parameter int         GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] inp_a,
    input  logic [15:0] inp_b,
    input  logic [15:0] inp_c,
    input  logic [15:0] inp_d,
    input  logic [15:0] inp_e,
    input  logic [15:0] inp_f,
    input  logic [15:0] inp_g,
    input  logic [15:0] inp_h,
    output logic [15:0] dac_a,
    output logic [15:0] dac_b,
    output logic [15:0] dac_c,
    output logic [15:0] dac_d,
    output logic [15:0] dac_e,
    output logic [15:0] dac_f,
    output logic [15:0] dac_g,
    output logic [15:0] dac_h,
    output logic [23:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        tx_done,
    output logic        busy,
    output logic [7:0]  pending
);

    localparam int CW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t         r_state;
    logic [15:0]    r_dac [8];
    logic [7:0]     r_force;
    logic [2:0]     r_last;
    logic [2:0]     r_ch;
    logic [CW-1:0]  r_gap_cnt;
    logic [23:0]    r_tx_data;
    logic           r_tx_valid;

    logic [15:0]    w_inp [8];
    logic [7:0]     w_pending;
    logic           w_found;
    logic [2:0]     w_win;

    assign w_inp[0] = inp_a;
    assign w_inp[1] = inp_b;
    assign w_inp[2] = inp_c;
    assign w_inp[3] = inp_d;
    assign w_inp[4] = inp_e;
    assign w_inp[5] = inp_f;
    assign w_inp[6] = inp_g;
    assign w_inp[7] = inp_h;

    // A channel needs a write while forced or while its request differs from the part.
    always_comb begin
        for (int n = 0; n < 8; n++) begin
            w_pending[n] = r_force[n] | (w_inp[n] != r_dac[n]);
        end
    end

    // Round-robin pick: search last+1, last+2, ... wrapping; the first pending channel wins.
    always_comb begin
        // NOTE: defaults assigned before the loop so every path drives both outputs and no latch is inferred.
        w_found = 1'b0;
        w_win   = r_last;
        for (int k = 1; k <= 8; k++) begin
            if (!w_found && w_pending[3'(r_last + 3'(k))]) begin
                w_found = 1'b1;
                w_win   = 3'(r_last + 3'(k));
            end
        end
    end

    // Scheduler FSM: selects, offers, waits for frame completion, commits, then holds off for the CS/LD gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            // NOTE: the DAC shadow is a small register bank rather than a RAM, and it must read zero after reset,
            // so it is reset along with the control state.
            r_dac      <= '{default: '0};
            r_force    <= 8'hFF;
            r_last     <= 3'd7;
            r_ch       <= 3'd0;
            r_gap_cnt  <= '0;
        end else begin
            // NOTE: all state updates are non-blocking so every register samples pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_ch       <= w_win;
                        r_tx_data  <= {CMD_WR_UPD, 1'b0, w_win, w_inp[w_win]};
                        r_tx_valid <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_done) begin
                        // Commit the snapshot that was sent; a newer request stays pending.
                        r_dac[r_ch]   <= r_tx_data[15:0];
                        r_force[r_ch] <= 1'b0;
                        r_last        <= r_ch;
                        r_gap_cnt     <= CW'(GAP_CYCLES);
                        r_state       <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = (r_state != S_IDLE);
    assign pending  = w_pending;

    assign dac_a = r_dac[0];
    assign dac_b = r_dac[1];
    assign dac_c = r_dac[2];
    assign dac_d = r_dac[3];
    assign dac_e = r_dac[4];
    assign dac_f = r_dac[5];
    assign dac_g = r_dac[6];
    assign dac_h = r_dac[7];

endmodule

// File: tb/tb_ltc2656_update_scheduler.sv
// Testbench for ltc2656_update_scheduler.
// Expected commands are queued when stimulus is applied and are compared when
// the SPI master model accepts a command. An SPI frame lasts 10 clocks.

module tb_ltc2656_update_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] inp_a, inp_b, inp_c, inp_d, inp_e, inp_f, inp_g, inp_h;
    logic [15:0] dac_a, dac_b, dac_c, dac_d, dac_e, dac_f, dac_g, dac_h;
    logic [23:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_done;
    logic        resp_done;
    logic        spur_done;
    logic        busy;
    logic [7:0]  pending;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] exp_q [$];
    int          done_cnt = 0;

    assign tx_done = resp_done | spur_done;

    ltc2656_update_scheduler #(
        .CMD_WR_UPD (4'b0011),
        .GAP_CYCLES (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .inp_a    (inp_a),
        .inp_b    (inp_b),
        .inp_c    (inp_c),
        .inp_d    (inp_d),
        .inp_e    (inp_e),
        .inp_f    (inp_f),
        .inp_g    (inp_g),
        .inp_h    (inp_h),
        .dac_a    (dac_a),
        .dac_b    (dac_b),
        .dac_c    (dac_c),
        .dac_d    (dac_d),
        .dac_e    (dac_e),
        .dac_f    (dac_f),
        .dac_g    (dac_g),
        .dac_h    (dac_h),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .busy     (busy),
        .pending  (pending)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Wait until every queued command was sent and the DUT is back in idle.
    task automatic drain(input string tag);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || busy || done_cnt != 0) && i < 2000) begin
            @(posedge clk);
            #1;
            i++;
        end
        check({tag, "_drain_in_time"}, 32'(i < 2000), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the DUT has accepted a command and awaits tx_done.
    task automatic wait_in_flight(input string tag);
        int i;
        i = 0;
        while (!(busy && !tx_valid && done_cnt != 0) && i < 100) begin
            @(posedge clk);
            #1;
            i++;
        end
        check({tag, "_in_flight"}, 32'(i < 100), 32'd1);
    endtask

    // SPI master model: predicts acceptance at the coming edge, scores the command, and pulses tx_done later.
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (reset) begin
                done_cnt = 0;
            end else begin
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) resp_done = 1'b1;
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $error("FAIL cmd_unexpected: observed=%h expected=none", tx_data);
                    end else begin
                        check("cmd", {8'h0, tx_data}, {8'h0, exp_q.pop_front()});
                    end
                    done_cnt = 10;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        reset     = 1'b1;
        tx_ready  = 1'b1;
        spur_done = 1'b0;
        {inp_a, inp_b, inp_c, inp_d} = '0;
        {inp_e, inp_f, inp_g, inp_h} = '0;

        // Reset state with all inputs at zero.
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data",  32'(tx_data),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_pending",  32'(pending),  32'h0000_00FF);
        check("rst_dac_a",    32'(dac_a),    32'd0);

        // Post-reset rewrite of all eight channels, channel A first.
        for (int n = 0; n < 8; n++) exp_q.push_back({4'h3, 4'(n), 16'h0000});
        reset = 1'b0;
        drain("init");
        check("init_pending", 32'(pending), 32'd0);
        check("init_busy",    32'(busy),    32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("init_quiet", 32'(tx_valid), 32'd0);

        // Single change on channel C.
        inp_c = 16'h1234;
        exp_q.push_back(24'h321234);
        drain("chc");
        check("chc_dac_c", 32'(dac_c), 32'h1234);
        check("chc_dac_a", 32'(dac_a), 32'h0000);
        check("chc_dac_h", 32'(dac_h), 32'h0000);

        // Serve channel E so the round-robin pointer sits at 4.
        inp_e = 16'h0E0E;
        exp_q.push_back(24'h340E0E);
        drain("che");
        check("che_dac_e", 32'(dac_e), 32'h0E0E);

        // B and G pending together: G comes after E, B wraps around later.
        inp_b = 16'h00AA;
        inp_g = 16'h00BB;
        exp_q.push_back(24'h3600BB);
        exp_q.push_back(24'h3100AA);
        drain("rr");
        check("rr_dac_b", 32'(dac_b), 32'h00AA);
        check("rr_dac_g", 32'(dac_g), 32'h00BB);

        // Request changes mid-transfer: snapshot committed first, then rewritten.
        inp_a = 16'h1111;
        exp_q.push_back(24'h301111);
        exp_q.push_back(24'h302222);
        wait_in_flight("snap");
        inp_a = 16'h2222;
        i = 0;
        while (dac_a === 16'h0000 && i < 100) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("snap_first_commit",   32'(dac_a),   32'h1111);
        check("snap_still_pending",  32'(pending[0]), 32'd1);
        drain("snap");
        check("snap_second_commit", 32'(dac_a), 32'h2222);

        // tx_ready held low for 50 clocks with D (and H) pending; spurious tx_done ignored.
        tx_ready = 1'b0;
        inp_d    = 16'hBEEF;
        inp_h    = 16'h7777;
        exp_q.push_back(24'h33BEEF);
        exp_q.push_back(24'h377777);
        i = 0;
        while (!tx_valid && i < 10) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("stall_valid_rise", 32'(tx_valid), 32'd1);
        for (int k = 0; k < 50; k++) begin
            spur_done = (k == 10 || k == 30);
            @(posedge clk);
            #1;
            spur_done = 1'b0;
            if (k % 10 == 0) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data",  32'(tx_data),  32'h0033_BEEF);
            end
        end
        check("stall_dac_d", 32'(dac_d), 32'h0000);
        check("stall_busy",  32'(busy),  32'd1);
        tx_ready = 1'b1;
        i = 0;
        while (dac_d !== 16'hBEEF && i < 100) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("gap_dac_d", 32'(dac_d), 32'hBEEF);
        for (int k = 0; k < 6; k++) begin
            check("gap_valid_low", 32'(tx_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        drain("gap");
        check("gap_dac_h", 32'(dac_h), 32'h7777);

        // Spurious tx_done while idle.
        spur_done = 1'b1;
        @(posedge clk);
        #1;
        spur_done = 1'b0;
        @(posedge clk);
        #1;
        check("spur_idle_busy",    32'(busy),    32'd0);
        check("spur_idle_pending", 32'(pending), 32'd0);

        // Reset in the middle of a transfer.
        inp_f = 16'h5555;
        exp_q.push_back(24'h355555);
        drain("chf");
        check("chf_dac_f", 32'(dac_f), 32'h5555);
        inp_f = 16'h6666;
        exp_q.push_back(24'h356666);
        wait_in_flight("mid");
        reset = 1'b1;
        #1;
        check("mid_rst_valid",   32'(tx_valid), 32'd0);
        check("mid_rst_busy",    32'(busy),     32'd0);
        check("mid_rst_dac_f",   32'(dac_f),    32'd0);
        check("mid_rst_dac_a",   32'(dac_a),    32'd0);
        check("mid_rst_dac_d",   32'(dac_d),    32'd0);
        check("mid_rst_pending", 32'(pending),  32'h0000_00FF);
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back({8'h30, inp_a});
        exp_q.push_back({8'h31, inp_b});
        exp_q.push_back({8'h32, inp_c});
        exp_q.push_back({8'h33, inp_d});
        exp_q.push_back({8'h34, inp_e});
        exp_q.push_back({8'h35, inp_f});
        exp_q.push_back({8'h36, inp_g});
        exp_q.push_back({8'h37, inp_h});
        reset = 1'b0;
        drain("rewrite");
        check("rewrite_pending", 32'(pending), 32'd0);
        check("rewrite_dac_f",   32'(dac_f),   32'h6666);
        check("rewrite_dac_b",   32'(dac_b),   32'h00AA);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
